mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit for the MEM stage of the 32-bit big-endian MIPS pipeline.
- Replaces read-splice stores with byte-enable writes.
- Talks to a variable-latency data memory through a req/ack handshake with timeout, and back-pressures the pipeline through op_ready.
- Supports all sub-word and unaligned (LWL/LWR/SWL/SWR) accesses.

Parameters:
- ADDR_W, 32, address width; dm_addr is word-aligned (low 2 bits zero).
- TIMEOUT_CYC, 64, cycles waiting for dm_ack before aborting; legal range 1..65535.
- CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- op_valid  in  1  pipeline presents an operation.
- op_ready  out  1  unit can accept; high only in IDLE.
- op_code  in  6  ALU_Control encoding (listed in Behaviour).
- addr  in  ADDR_W  effective address, or ALU result for non-memory ops.
- store_data  in  32  rt value for stores.
- reg_old  in  32  current destination register value, used for the LWL/LWR merge.
- wreg_in  in  5  destination register.
- regwrite_in  in  1  destination write enable.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  32  writeback data.
- res_reg  out  5  registered copy of wreg_in.
- res_regwrite  out  1  registered regwrite_in, forced to 0 on error.
- res_err  out  1  misalignment or timeout; qualified by res_valid.
- dm_req  out  1  memory request, held until ack.
- dm_we  out  1  1 = write.
- dm_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- dm_be  out  4  byte enables; be[3] = bits 31:24 = byte offset 0.
- dm_wdata  out  32  lane-aligned write data.
- dm_ack  in  1  memory completion; dm_rdata is valid in the same cycle.
- dm_rdata  in  32  read word.

Behaviour:
- Op codes:
  - LB 100001, LH 101011, LBU 101010, LHU 101100.
  - LW 111101, LL 101000, LWC1 110101, LWL 101101, LWR 101110.
  - SB 101111, SH 110000, SW 110001, SC 110110, SWL 110010, SWR 110011.
  - Any other code (including 000000) is non-memory.
- Reset values: op_ready=0 during reset, 1 in IDLE after reset. All other outputs are 0, state = IDLE, link_valid = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: accept on op_valid && op_ready; latch all inputs.
  - Non-memory op → RESP; res_data = addr.
  - Misaligned op → RESP with res_err=1, no dm_req. Misaligned means: LH/LHU/SH with addr[0]=1; LW/LL/LWC1/SW/SC with addr[1:0]≠0.
  - Otherwise → ACCESS.
- ACCESS: dm_req=1, with dm_we/addr/be/wdata stable until dm_ack. Timeout counter clears on entry and increments each cycle.
  - dm_ack → RESP, capture the merged result.
  - Counter == TIMEOUT_CYC-1 without ack → deassert dm_req, go to RESP with res_err=1.
  - dm_ack and timeout in the same cycle: ack wins.
- RESP: res_valid=1 for exactly one cycle, then → IDLE. op_ready is 0 in ACCESS and RESP.
- Minimum latency: accept at T, dm_req at T+1, ack at T+1 → res_valid at T+2. Non-memory ops: res_valid at T+1.
- Load formatting, k = addr[1:0], big-endian:
  - LB/LBU: byte k sign- or zero-extended.
  - LH/LHU: half k[1] sign- or zero-extended.
  - LWL: (dm_rdata << 8k) | (reg_old & ~(32'hFFFFFFFF << 8k)).
  - LWR: (dm_rdata >> 8(3-k)) | (reg_old & ~(32'hFFFFFFFF >> 8(3-k))).
- Loads drive dm_be=4'b1111.
- Stores:
  - SB: be = 4'b1000 >> k; wdata = {4{store_data[7:0]}}.
  - SH: be = k[1] ? 0011 : 1100; wdata = {2{store_data[15:0]}}.
  - SW/SC: be=1111.
  - SWL: be = 4'b1111 >> k; wdata = store_data >> 8k.
  - SWR: be = (4'b1111 << (3-k)) & 4'b1111; wdata = store_data << 8(3-k).
- Store result: res_data = 0 for stores other than SC.
- On error, res_regwrite=0 and res_data=0.
- RESET asserted mid-ACCESS: dm_req drops asynchronously, the operation is discarded, and no res_valid is produced.

Optional Feature:
- Macro: MEM_ACCESS_LLSC_EN.
- Defined:
  - LL success sets link_valid=1 and link_addr=addr[ADDR_W-1:2].
  - SC with link_valid && address match performs the write and returns res_data=1.
  - Otherwise SC issues no dm_req, returns res_data=0 (no error), and reaches RESP in one cycle.
  - Any SC, and any other store to the linked word, clears link_valid.
- Undefined: SC behaves as SW and returns res_data=1; no link state exists.

Test Plan:
- LB at addr 0x103, dm_rdata 0x123456F0, ack 1 cycle after req → res_data 0xFFFFFFF0, res_valid at T+2, dm_be 1111.
- LWL addr 0x201, reg_old 0xAABBCCDD, rdata 0x11223344 → 0x223344DD. LWR addr 0x201, same inputs → 0xAABB1122.
- SWR addr 0x302, store_data 0xDEADBEEF → dm_be 1110, dm_wdata 0xADBEEF00, res_regwrite as input. SH addr 0x302, data 0x0000CAFE → be 0011, wdata 0xCAFECAFE.
- LW addr 0x402 → no dm_req, res_err=1, res_regwrite=0 at T+1. SW with dm_ack withheld, TIMEOUT_CYC=4 → dm_req high 4 cycles then low, res_err=1.
- RESET pulsed 2 cycles into a pending ACCESS → dm_req=0 immediately, no res_valid, op_ready=1 after release.
- With MEM_ACCESS_LLSC_EN: LL 0x500, then SC 0x500 → write, res_data 1. Second SC 0x500 → no dm_req, res_data 0. LL 0x500, SB 0x501, SC 0x500 → res_data 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for a big-endian 32-bit MIPS pipeline.
// Ports: CLK, RESET (async, active high); op_valid/op_ready accept an op with
// op_code, addr, store_data, reg_old, wreg_in, regwrite_in; res_* give a one-cycle
// result strobe; dm_* drive a req/ack data memory using byte enables.
// Optional LL/SC link tracking is enabled by the macro MEM_ACCESS_LLSC_EN.
module mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [5:0]        op_code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       reg_old,
    input  logic [4:0]        wreg_in,
    input  logic              regwrite_in,
    output logic              res_valid,
    output logic [31:0]       res_data,
    output logic [4:0]        res_reg,
    output logic              res_regwrite,
    output logic              res_err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata
);

    localparam logic [5:0] OP_LB   = 6'b100001;
    localparam logic [5:0] OP_LH   = 6'b101011;
    localparam logic [5:0] OP_LBU  = 6'b101010;
    localparam logic [5:0] OP_LHU  = 6'b101100;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_LL   = 6'b101000;
    localparam logic [5:0] OP_LWC1 = 6'b110101;
    localparam logic [5:0] OP_LWL  = 6'b101101;
    localparam logic [5:0] OP_LWR  = 6'b101110;
    localparam logic [5:0] OP_SB   = 6'b101111;
    localparam logic [5:0] OP_SH   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_SC   = 6'b110110;
    localparam logic [5:0] OP_SWL  = 6'b110010;
    localparam logic [5:0] OP_SWR  = 6'b110011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [1:0]       k_q;
    logic [31:0]      reg_old_q;
    logic             rw_q;
    logic [CNT_W-1:0] cnt;

    // Decode of the incoming op, used only at accept time.
    logic        is_load, is_store, is_sc, misal;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  k;
    assign k = addr[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_sc    = 1'b0;
        misal    = 1'b0;
        be       = 4'b1111;
        wdata    = store_data;
        case (op_code)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                misal   = k[0];
            end
            OP_LW, OP_LL, OP_LWC1: begin
                is_load = 1'b1;
                misal   = |k;
            end
            OP_SB: begin
                is_store = 1'b1;
                be       = 4'b1000 >> k;
                wdata    = {4{store_data[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                misal    = k[0];
                be       = k[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{store_data[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                misal    = |k;
            end
            OP_SC: begin
                is_store = 1'b1;
                is_sc    = 1'b1;
                misal    = |k;
            end
            OP_SWL: begin
                is_store = 1'b1;
                be       = 4'b1111 >> k;
                wdata    = store_data >> {k, 3'b000};
            end
            OP_SWR: begin
                is_store = 1'b1;
                be       = 4'b1111 << ~k;
                wdata    = store_data << {~k, 3'b000};
            end
            default: ;
        endcase
    end

    // Result formatting at ack; ~k_q equals 3-k for a 2-bit offset.
    logic [4:0]  sh_l, sh_r;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ack_data;
    assign sh_l     = {k_q, 3'b000};
    assign sh_r     = {~k_q, 3'b000};
    assign byte_sel = 8'(dm_rdata >> sh_r);
    assign half_sel = k_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];

    always_comb begin
        ack_data = 32'd0;
        case (op_q)
            OP_LB:  ack_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: ack_data = {24'd0, byte_sel};
            OP_LH:  ack_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: ack_data = {16'd0, half_sel};
            OP_LW, OP_LL, OP_LWC1: ack_data = dm_rdata;
            OP_LWL: ack_data = (dm_rdata << sh_l)
                             | (reg_old_q & ~(32'hFFFF_FFFF << sh_l));
            OP_LWR: ack_data = (dm_rdata >> sh_r)
                             | (reg_old_q & ~(32'hFFFF_FFFF >> sh_r));
            OP_SC:  ack_data = 32'd1;
            default: ack_data = 32'd0;
        endcase
    end

    logic sc_fail;
`ifdef MEM_ACCESS_LLSC_EN
    logic              link_valid;
    logic [ADDR_W-3:0] link_addr;
    logic              link_hit;
    assign link_hit = link_valid && (link_addr == addr[ADDR_W-1:2]);
    assign sc_fail  = is_sc && !link_hit;
`else
    assign sc_fail  = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            op_ready     <= 1'b0;
            op_q         <= '0;
            k_q          <= '0;
            reg_old_q    <= '0;
            rw_q         <= 1'b0;
            cnt          <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_reg      <= '0;
            res_regwrite <= 1'b0;
            res_err      <= 1'b0;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_be        <= '0;
            dm_wdata     <= '0;
`ifdef MEM_ACCESS_LLSC_EN
            link_valid   <= 1'b0;
            link_addr    <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        op_q      <= op_code;
                        k_q       <= k;
                        reg_old_q <= reg_old;
                        rw_q      <= regwrite_in;
                        res_reg   <= wreg_in;
                        op_ready  <= 1'b0;
`ifdef MEM_ACCESS_LLSC_EN
                        if (is_sc || (is_store && !misal && link_hit))
                            link_valid <= 1'b0;
`endif
                        if (!(is_load || is_store)) begin
                            state        <= RESP;
                            res_valid    <= 1'b1;
                            res_data     <= 32'(addr);
                            res_err      <= 1'b0;
                            res_regwrite <= regwrite_in;
                        end else if (misal) begin
                            state        <= RESP;
                            res_valid    <= 1'b1;
                            res_data     <= '0;
                            res_err      <= 1'b1;
                            res_regwrite <= 1'b0;
                        end else if (sc_fail) begin
                            state        <= RESP;
                            res_valid    <= 1'b1;
                            res_data     <= '0;
                            res_err      <= 1'b0;
                            res_regwrite <= regwrite_in;
                        end else begin
                            state    <= ACCESS;
                            dm_req   <= 1'b1;
                            dm_we    <= is_store;
                            dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dm_be    <= be;
                            dm_wdata <= wdata;
                            cnt      <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        state        <= RESP;
                        dm_req       <= 1'b0;
                        res_valid    <= 1'b1;
                        res_data     <= ack_data;
                        res_err      <= 1'b0;
                        res_regwrite <= rw_q;
`ifdef MEM_ACCESS_LLSC_EN
                        if (op_q == OP_LL) begin
                            link_valid <= 1'b1;
                            link_addr  <= dm_addr[ADDR_W-1:2];
                        end
`endif
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state        <= RESP;
                        dm_req       <= 1'b0;
                        res_valid    <= 1'b1;
                        res_data     <= '0;
                        res_err      <= 1'b1;
                        res_regwrite <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit.
// Built with TIMEOUT_CYC=4; LL/SC checks follow MEM_ACCESS_LLSC_EN.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [5:0]  op_code = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [31:0] reg_old = '0;
    logic [4:0]  wreg_in = '0;
    logic        regwrite_in = 1'b0;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_reg;
    logic        res_regwrite;
    logic        res_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(4), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .addr(addr), .store_data(store_data), .reg_old(reg_old),
        .wreg_in(wreg_in), .regwrite_in(regwrite_in),
        .res_valid(res_valid), .res_data(res_data), .res_reg(res_reg),
        .res_regwrite(res_regwrite), .res_err(res_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    // Present one op for one accept edge; returns at the negedge after it.
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] ro);
        @(negedge CLK);
        op_valid    = 1'b1;
        op_code     = op;
        addr        = a;
        store_data  = sd;
        reg_old     = ro;
        wreg_in     = 5'd7;
        regwrite_in = 1'b1;
        @(negedge CLK);
        op_valid    = 1'b0;
    endtask

    // Acknowledge for one cycle; returns in the result cycle.
    task automatic ack_now(input logic [31:0] rd);
        dm_ack   = 1'b1;
        dm_rdata = rd;
        @(negedge CLK);
        dm_ack   = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge CLK);
        nvec++;
        if (op_ready !== 1'b0 || dm_req !== 1'b0 || res_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_hold: ready=%b req=%b valid=%b want 0 0 0",
                     op_ready, dm_req, res_valid);
        end
        RESET = 1'b0;
        @(negedge CLK);
        nvec++;
        if (op_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: got %b want 1", op_ready);
        end
    endtask

    task automatic test_lb;
        issue(6'b100001, 32'h103, 32'h0, 32'h0);
        nvec++;
        if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_be !== 4'b1111 ||
            dm_addr !== 32'h100 || op_ready !== 1'b0) begin
            nerr++;
            $display("FAIL lb_req: req=%b we=%b be=%b addr=%h rdy=%b want 1 0 1111 100 0",
                     dm_req, dm_we, dm_be, dm_addr, op_ready);
        end
        ack_now(32'h1234_56F0);
        nvec++;
        if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFF0 ||
            res_err !== 1'b0 || res_regwrite !== 1'b1 || res_reg !== 5'd7) begin
            nerr++;
            $display("FAIL lb_res: v=%b d=%h e=%b rw=%b r=%0d want 1 fffffff0 0 1 7",
                     res_valid, res_data, res_err, res_regwrite, res_reg);
        end
        @(negedge CLK);
        nvec++;
        if (res_valid !== 1'b0) begin
            nerr++;
            $display("FAIL lb_strobe: valid=%b want 0", res_valid);
        end
    endtask

    task automatic test_half;
        issue(6'b101011, 32'h102, 32'h0, 32'h0);
        ack_now(32'h1234_8765);
        nvec++;
        if (res_data !== 32'hFFFF_8765) begin
            nerr++;
            $display("FAIL lh: got %h want ffff8765", res_data);
        end
        issue(6'b101100, 32'h100, 32'h0, 32'h0);
        ack_now(32'h8765_1234);
        nvec++;
        if (res_data !== 32'h0000_8765) begin
            nerr++;
            $display("FAIL lhu: got %h want 00008765", res_data);
        end
    endtask

    task automatic test_unaligned_load;
        issue(6'b101101, 32'h201, 32'h0, 32'hAABB_CCDD);
        ack_now(32'h1122_3344);
        nvec++;
        if (res_data !== 32'h2233_44DD) begin
            nerr++;
            $display("FAIL lwl: got %h want 223344dd", res_data);
        end
        issue(6'b101110, 32'h201, 32'h0, 32'hAABB_CCDD);
        ack_now(32'h1122_3344);
        nvec++;
        if (res_data !== 32'hAABB_1122) begin
            nerr++;
            $display("FAIL lwr: got %h want aabb1122", res_data);
        end
    endtask

    task automatic test_stores;
        issue(6'b110011, 32'h302, 32'hDEAD_BEEF, 32'h0);
        nvec++;
        if (dm_we !== 1'b1 || dm_be !== 4'b1110 || dm_wdata !== 32'hADBE_EF00) begin
            nerr++;
            $display("FAIL swr_bus: we=%b be=%b wd=%h want 1 1110 adbeef00",
                     dm_we, dm_be, dm_wdata);
        end
        ack_now(32'h0);
        nvec++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || res_regwrite !== 1'b1) begin
            nerr++;
            $display("FAIL swr_res: v=%b d=%h rw=%b want 1 0 1",
                     res_valid, res_data, res_regwrite);
        end
        issue(6'b110000, 32'h302, 32'h0000_CAFE, 32'h0);
        nvec++;
        if (dm_be !== 4'b0011 || dm_wdata !== 32'hCAFE_CAFE) begin
            nerr++;
            $display("FAIL sh_bus: be=%b wd=%h want 0011 cafecafe", dm_be, dm_wdata);
        end
        ack_now(32'h0);
        issue(6'b101111, 32'h101, 32'h0000_005A, 32'h0);
        nvec++;
        if (dm_be !== 4'b0100 || dm_wdata !== 32'h5A5A_5A5A) begin
            nerr++;
            $display("FAIL sb_bus: be=%b wd=%h want 0100 5a5a5a5a", dm_be, dm_wdata);
        end
        ack_now(32'h0);
        issue(6'b110010, 32'h301, 32'hDEAD_BEEF, 32'h0);
        nvec++;
        if (dm_be !== 4'b0111 || dm_wdata !== 32'h00DE_ADBE || dm_addr !== 32'h300) begin
            nerr++;
            $display("FAIL swl_bus: be=%b wd=%h a=%h want 0111 00deadbe 300",
                     dm_be, dm_wdata, dm_addr);
        end
        ack_now(32'h0);
    endtask

    task automatic test_misalign;
        issue(6'b111101, 32'h402, 32'h0, 32'h0);
        nvec++;
        if (dm_req !== 1'b0 || res_valid !== 1'b1 || res_err !== 1'b1 ||
            res_regwrite !== 1'b0 || res_data !== 32'h0) begin
            nerr++;
            $display("FAIL lw_misalign: req=%b v=%b e=%b rw=%b d=%h want 0 1 1 0 0",
                     dm_req, res_valid, res_err, res_regwrite, res_data);
        end
    endtask

    task automatic test_nonmem;
        issue(6'b000000, 32'hCAFE_BABE, 32'h0, 32'h0);
        nvec++;
        if (res_valid !== 1'b1 || res_data !== 32'hCAFE_BABE ||
            res_err !== 1'b0 || dm_req !== 1'b0) begin
            nerr++;
            $display("FAIL nonmem: v=%b d=%h e=%b req=%b want 1 cafebabe 0 0",
                     res_valid, res_data, res_err, dm_req);
        end
    endtask

    task automatic test_timeout;
        int  high = 0;
        bit  seen = 1'b0;
        logic err = 1'b0;
        issue(6'b110001, 32'h600, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (res_valid === 1'b1) begin
                seen = 1'b1;
                err  = res_err;
                break;
            end
            if (dm_req === 1'b1) high++;
            @(negedge CLK);
        end
        nvec++;
        if (!seen || high != 4 || err !== 1'b1 || dm_req !== 1'b0) begin
            nerr++;
            $display("FAIL timeout: seen=%b req_cycles=%0d err=%b req=%b want 1 4 1 0",
                     seen, high, err, dm_req);
        end
    endtask

    task automatic test_reset_mid;
        int vcnt = 0;
        issue(6'b111101, 32'h700, 32'h0, 32'h0);
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        nvec++;
        if (dm_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_req: got %b want 0", dm_req);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (res_valid === 1'b1) vcnt++;
        end
        nvec++;
        if (vcnt != 0 || op_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_mid_after: valids=%0d ready=%b want 0 1", vcnt, op_ready);
        end
    endtask

    task automatic test_sc;
`ifdef MEM_ACCESS_LLSC_EN
        issue(6'b101000, 32'h500, 32'h0, 32'h0);
        ack_now(32'h0);
        issue(6'b110110, 32'h500, 32'h55, 32'h0);
        nvec++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1) begin
            nerr++;
            $display("FAIL sc_ok_bus: req=%b we=%b want 1 1", dm_req, dm_we);
        end
        ack_now(32'h0);
        nvec++;
        if (res_data !== 32'd1) begin
            nerr++;
            $display("FAIL sc_ok_res: got %h want 1", res_data);
        end
        issue(6'b110110, 32'h500, 32'h55, 32'h0);
        nvec++;
        if (dm_req !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'd0 ||
            res_err !== 1'b0) begin
            nerr++;
            $display("FAIL sc_again: req=%b v=%b d=%h e=%b want 0 1 0 0",
                     dm_req, res_valid, res_data, res_err);
        end
        issue(6'b101000, 32'h500, 32'h0, 32'h0);
        ack_now(32'h0);
        issue(6'b101111, 32'h501, 32'h0, 32'h0);
        ack_now(32'h0);
        issue(6'b110110, 32'h500, 32'h55, 32'h0);
        nvec++;
        if (dm_req !== 1'b0 || res_data !== 32'd0) begin
            nerr++;
            $display("FAIL sc_after_sb: req=%b d=%h want 0 0", dm_req, res_data);
        end
`else
        issue(6'b110110, 32'h800, 32'h55, 32'h0);
        nvec++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_be !== 4'b1111 ||
            dm_wdata !== 32'h55) begin
            nerr++;
            $display("FAIL sc_bus: req=%b we=%b be=%b wd=%h want 1 1 1111 55",
                     dm_req, dm_we, dm_be, dm_wdata);
        end
        ack_now(32'h0);
        nvec++;
        if (res_data !== 32'd1 || res_err !== 1'b0) begin
            nerr++;
            $display("FAIL sc_res: d=%h e=%b want 1 0", res_data, res_err);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_lb;
        test_half;
        test_unaligned_load;
        test_stores;
        test_misalign;
        test_nonmem;
        test_timeout;
        test_reset_mid;
        test_sc;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
